// File: rtl/bin_to_bcd.sv
// bin_to_bcd
// ----------
// Sequential binary-to-BCD converter feeding the 4-digit 7-segment display
// driver. A start pulse captures a 14-bit value, a shift-and-add-3 (double
// dabble) loop processes one bit per clock, and the result is presented as a
// registered packed BCD word with a one-cycle done strobe. Inputs above 9999
// saturate to 9999 and raise ovf.
//
// Ports
//   clk    in   1   system clock, rising edge active
//   reset  in   1   synchronous active-low reset
//   start  in   1   request a conversion of bin (accepted in IDLE, or in
//                   FINISH so that a held start runs back-to-back)
//   bin    in  14   unsigned binary value, captured on the accepting edge
//   bcd    out 16   {thousands, hundreds, tens, units}, held until next result
//   busy   out  1   high in every SHIFT and FINISH cycle
//   done   out  1   one-cycle pulse when bcd/ovf have just been updated
//   ovf    out  1   last captured value exceeded 9999 (bcd saturated)

module bin_to_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t      state;

  // Working register: upper 16 bits are the BCD digits being built, lower
  // 14 bits are the binary value being shifted out MSB first.
  logic [29:0] shift_reg;
  logic [3:0]  bit_cnt;
  logic        sat;
  logic [15:0] bcd_adj;

  // Add-3 correction for one digit; 4-bit wrap is fine because a digit
  // never exceeds 9 for non-saturating inputs.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // All four digits are corrected in parallel from the current value,
  // with no carry between digits, before the shift.
  always_comb begin
    bcd_adj         = '0;
    bcd_adj[15:12]  = add3(shift_reg[29:26]);
    bcd_adj[11:8]   = add3(shift_reg[25:22]);
    bcd_adj[7:4]    = add3(shift_reg[21:18]);
    bcd_adj[3:0]    = add3(shift_reg[17:14]);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      sat       <= 1'b0;
      bcd       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= {16'h0000, bin};
            bit_cnt   <= 4'd14;
            sat       <= (bin > 14'd9999);
            state     <= SHIFT;
            busy      <= 1'b1;
          end
        end

        SHIFT: begin
          shift_reg <= {bcd_adj[14:0], shift_reg[13:0], 1'b0};
          bit_cnt   <= bit_cnt - 4'd1;
          if (bit_cnt == 4'd1) begin
            state <= FINISH;
          end
        end

        FINISH: begin
          bcd  <= sat ? 16'h9999 : shift_reg[29:14];
          ovf  <= sat;
          done <= 1'b1;
          // A start present on the finishing edge is taken immediately so a
          // held start yields one result every 15 clocks.
          if (start) begin
            shift_reg <= {16'h0000, bin};
            bit_cnt   <= 4'd14;
            sat       <= (bin > 14'd9999);
            state     <= SHIFT;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd
// -------------
// Scoreboard bench for bin_to_bcd: expected {bcd, ovf} pairs are queued when a
// conversion is started and compared whenever the DUT raises done.

module tb_bin_to_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        ovf;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_seen = 0;
  logic [16:0] sb[$];
  logic [16:0] sb_head;

  bin_to_bcd dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Free-running posedge counter used for latency and spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: decimal digit extraction, saturating at 9999.
  function automatic logic [16:0] expectedOf(input int v);
    if (v > 9999) return {16'h9999, 1'b1};
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), 1'b0};
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        checkOutput("spurious_done", 32'd1, 32'd0);
      end else begin
        sb_head = sb.pop_front();
        checkOutput("bcd", {16'h0, bcd}, {16'h0, sb_head[16:1]});
        checkOutput("ovf", {31'h0, ovf}, {31'h0, sb_head[0]});
      end
    end
  end

  // One complete conversion; optionally checks latency, busy and done width.
  task automatic applyStimulus(input int v, input bit check_timing);
    int c0;
    int busy_cycles;
    int n;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'(v);
    sb.push_back(expectedOf(v));
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    bin   = 14'($urandom);
    busy_cycles = 0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else if (check_timing) begin
      checkOutput("latency", cyc - (c0 + 1), 32'd15);
      checkOutput("busy_cycles", busy_cycles, 32'd15);
      checkOutput("busy_after_done", {31'h0, busy}, 32'd0);
      @(negedge clk);
      checkOutput("done_width", {31'h0, done}, 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ds;
    int n;
    int vals[5];
    int dc[5];

    // Reset held for three clocks, then idle with no start.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("reset_idle", {12'h0, bcd, busy, done, ovf}, 32'd0);
    end

    // Single conversion and result hold.
    applyStimulus(4321, 1'b1);
    ds = done_seen;
    repeat (100) @(negedge clk);
    checkOutput("hold_bcd", {16'h0, bcd}, 32'h4321);
    checkOutput("hold_no_done", done_seen - ds, 32'd0);

    // Sampled sweep across the valid range plus both ends.
    for (int v = 0; v <= 9999; v += 7) applyStimulus(v, 1'b0);
    applyStimulus(9999, 1'b1);

    // Saturation then recovery.
    applyStimulus(10000, 1'b1);
    applyStimulus(16383, 1'b1);
    applyStimulus(7, 1'b1);

    // Starts during SHIFT (edges 5 and 14) are ignored.
    ds = done_seen;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1234;
    sb.push_back(expectedOf(1234));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("ignored_start_dones", done_seen - ds, 32'd1);
    checkOutput("ignored_start_bcd", {16'h0, bcd}, 32'h1234);

    // Start held high: a new value is taken on each finishing edge.
    vals = '{2468, 135, 9999, 12000, 42};
    @(negedge clk);
    start = 1'b1;
    bin   = 14'(vals[0]);
    for (int i = 0; i < 5; i++) sb.push_back(expectedOf(vals[i]));
    @(negedge clk);
    bin = 14'(vals[1]);
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done !== 1'b1 && n < 40);
      if (done !== 1'b1) checkOutput("b2b_timeout", 32'd0, 32'd1);
      dc[i] = cyc;
      checkOutput("b2b_busy", {31'h0, busy}, (i < 4) ? 32'd1 : 32'd0);
      if (i + 2 < 5) bin = 14'(vals[i + 2]);
      if (i == 3) start = 1'b0;
    end
    for (int i = 1; i < 5; i++) checkOutput("b2b_interval", dc[i] - dc[i - 1], 32'd15);

    // Reset at clock 7 of a conversion aborts it and clears the result.
    applyStimulus(4321, 1'b1);
    ds = done_seen;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd9999;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("abort_bcd", {16'h0, bcd}, 32'd0);
    checkOutput("abort_flags", {29'h0, busy, done, ovf}, 32'd0);
    repeat (30) @(negedge clk);
    checkOutput("abort_no_done", done_seen - ds, 32'd0);
    applyStimulus(8765, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
